// File: rtl/ysyx_23060191_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encodings,
// trap cause codes and the bit positions used inside mstatus/mie/mip.
package ysyx_23060191_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned CAUSE_ECALL_M = 11;
  localparam int unsigned CAUSE_MTI     = 7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

endpackage

// File: rtl/ysyx_23060191_csr_counter.sv
// 64-bit free-running counter with per-half and full-width software writes;
// any write in a cycle suppresses that cycle's increment.
module ysyx_23060191_csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        wr_full_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_full_i) begin
      count_d = wdata_i;
    end else if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i[31:0];
      if (wr_hi_i) count_d[63:32] = wdata_i[31:0];
    end else if (inc_en_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/ysyx_23060191_csr_unit.sv
// Machine-mode CSR file: Zicsr read/modify/write, ecall and timer-interrupt
// trap entry, mret, and the mcycle/minstret counters.
module ysyx_23060191_csr_unit
  import ysyx_23060191_csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic            i_ecall_en,
  input  logic            i_mret_en,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_retire,
  input  logic            i_irq_timer,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_illegal,
  output logic            o_trap_valid,
  output logic [XLEN-1:0] o_trap_pc,
  output logic [XLEN-1:0] o_mepc
);

  localparam bit              IS_RV32    = (XLEN == 32);
  localparam bit              HAS_HI     = HAS_COUNTERS && IS_RV32;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  csr_op_e         op;
  logic            mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mstatusVal, mieVal, mipVal, rdata, wvalue;
  logic [63:0]     mcycle, minstret;
  logic            mapped, doWrite, illegal, writeEn;
  logic            ecallTrap, irqTrap, trapTaken, mretTaken;

  assign op = csr_op_e'(i_csr_op);

  always_comb begin
    mstatusVal = '0;
    mstatusVal[MSTATUS_MIE]          = mie_q;
    mstatusVal[MSTATUS_MPIE]         = mpie_q;
    mstatusVal[MSTATUS_MPP_LO +: 2]  = 2'b11;
    mieVal = '0;
    mieVal[MIE_MTIE] = mtie_q;
    mipVal = '0;
    mipVal[MIP_MTIP] = i_irq_timer;
  end

  // Counter addresses only decode when the counters (and, for the high
  // halves, a 32-bit datapath) exist; everything else reads as unmapped.
  always_comb begin
    mapped = 1'b1;
    rdata  = '0;
    case (i_csr_addr)
      CSR_MSTATUS: rdata = mstatusVal;
      CSR_MIE:     rdata = mieVal;
      CSR_MTVEC:   rdata = mtvec_q;
      CSR_MEPC:    rdata = mepc_q;
      CSR_MCAUSE:  rdata = mcause_q;
      CSR_MIP:     rdata = mipVal;
      CSR_MCYCLE:    if (HAS_COUNTERS) rdata = XLEN'(mcycle);           else mapped = 1'b0;
      CSR_MINSTRET:  if (HAS_COUNTERS) rdata = XLEN'(minstret);         else mapped = 1'b0;
      CSR_MCYCLEH:   if (HAS_HI)       rdata = XLEN'(mcycle[63:32]);    else mapped = 1'b0;
      CSR_MINSTRETH: if (HAS_HI)       rdata = XLEN'(minstret[63:32]);  else mapped = 1'b0;
      default:     mapped = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RW: wvalue = i_csr_wdata;
      CSR_OP_RS: wvalue = rdata | i_csr_wdata;
      CSR_OP_RC: wvalue = rdata & ~i_csr_wdata;
      default:   wvalue = rdata;
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
  assign doWrite = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && (i_csr_wdata != '0));
  assign illegal = (op != CSR_OP_NONE) &&
                   (!mapped || (doWrite && ((i_csr_addr == CSR_MIP) || (i_csr_addr[11:10] == 2'b11))));
  assign writeEn = doWrite && !illegal;

  assign ecallTrap = i_ecall_en;
  assign irqTrap   = mie_q && mtie_q && i_irq_timer && i_retire && !i_ecall_en;
  assign trapTaken = ecallTrap || irqTrap;
  assign mretTaken = i_mret_en && !trapTaken;

  assign o_csr_rdata  = rdata;
  assign o_illegal    = illegal;
  assign o_trap_valid = trapTaken || mretTaken;
  assign o_trap_pc    = trapTaken ? mtvec_q : (mretTaken ? mepc_q : '0);
  assign o_mepc       = mepc_q;

  // Trap/mret updates are applied after the software write so they win on
  // the CSRs they touch; writes to other CSRs in the same cycle still land.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (writeEn) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wvalue[MSTATUS_MIE];
          mpie_d = wvalue[MSTATUS_MPIE];
        end
        CSR_MIE:    mtie_d   = wvalue[MIE_MTIE];
        CSR_MTVEC:  mtvec_d  = wvalue & ALIGN_MASK;
        CSR_MEPC:   mepc_d   = wvalue & ALIGN_MASK;
        CSR_MCAUSE: mcause_d = wvalue;
        default: ;
      endcase
    end
    if (trapTaken) begin
      mepc_d   = i_pc & ALIGN_MASK;
      mcause_d = ecallTrap ? XLEN'(CAUSE_ECALL_M) : {1'b1, (XLEN-1)'(CAUSE_MTI)};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mretTaken) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET & ALIGN_MASK;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    logic [63:0] cntWdata;
    logic        wrCycLo, wrCycHi, wrCycFull, wrInsLo, wrInsHi, wrInsFull;

    // On RV32 the base address is the low half; on RV64 it is the whole counter.
    assign cntWdata  = 64'(wvalue);
    assign wrCycLo   = writeEn && (i_csr_addr == CSR_MCYCLE)    &&  IS_RV32;
    assign wrCycFull = writeEn && (i_csr_addr == CSR_MCYCLE)    && !IS_RV32;
    assign wrCycHi   = writeEn && (i_csr_addr == CSR_MCYCLEH);
    assign wrInsLo   = writeEn && (i_csr_addr == CSR_MINSTRET)  &&  IS_RV32;
    assign wrInsFull = writeEn && (i_csr_addr == CSR_MINSTRET)  && !IS_RV32;
    assign wrInsHi   = writeEn && (i_csr_addr == CSR_MINSTRETH);

    ysyx_23060191_csr_counter u_mcycle (
      .clk       (clk),
      .rst       (rst),
      .inc_en_i  (1'b1),
      .wr_lo_i   (wrCycLo),
      .wr_hi_i   (wrCycHi),
      .wr_full_i (wrCycFull),
      .wdata_i   (cntWdata),
      .count_o   (mcycle)
    );

    ysyx_23060191_csr_counter u_minstret (
      .clk       (clk),
      .rst       (rst),
      .inc_en_i  (i_retire),
      .wr_lo_i   (wrInsLo),
      .wr_hi_i   (wrInsHi),
      .wr_full_i (wrInsFull),
      .wdata_i   (cntWdata),
      .count_o   (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule

// File: tb/tb_ysyx_23060191_csr_unit.sv
// Directed bench for the CSR unit: stimulus pushes expected responses into a
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_ysyx_23060191_csr_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0000;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] RW   = 2'b01;
  localparam logic [1:0] RS   = 2'b10;
  localparam logic [1:0] RC   = 2'b11;

  logic            clk, rst;
  logic [1:0]      csrOp;
  logic [11:0]     csrAddr;
  logic [XLEN-1:0] csrWdata, pc;
  logic            ecallEn, mretEn, retire, irqTimer;
  logic [XLEN-1:0] csrRdata, trapPc, mepcOut;
  logic            illegal, trapValid;

  typedef struct packed {
    logic        chkRd;
    logic [31:0] rd;
    logic        ill;
    logic        tv;
    logic [31:0] tpc;
    logic        chkMepc;
    logic [31:0] mepc;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  sampleEn = 1'b0;

  ysyx_23060191_csr_unit #(
    .XLEN         (XLEN),
    .MTVEC_RESET  (MTVEC_RST),
    .HAS_COUNTERS (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_csr_op     (csrOp),
    .i_csr_addr   (csrAddr),
    .i_csr_wdata  (csrWdata),
    .i_ecall_en   (ecallEn),
    .i_mret_en    (mretEn),
    .i_pc         (pc),
    .i_retire     (retire),
    .i_irq_timer  (irqTimer),
    .o_csr_rdata  (csrRdata),
    .o_illegal    (illegal),
    .o_trap_valid (trapValid),
    .o_trap_pc    (trapPc),
    .o_mepc       (mepcOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (sampleEn) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL monitor: DUT output sampled with no expectation queued");
      end else begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, "illegal", {31'b0, illegal}, {31'b0, e.ill});
        checkOutput(n, "trap_valid", {31'b0, trapValid}, {31'b0, e.tv});
        checkOutput(n, "trap_pc", trapPc, e.tpc);
        if (e.chkRd)   checkOutput(n, "rdata", csrRdata, e.rd);
        if (e.chkMepc) checkOutput(n, "mepc", mepcOut, e.mepc);
      end
    end
  end

  task automatic applyStimulus(
    input string name, input logic rstV, input logic [1:0] op, input logic [11:0] addr,
    input logic [31:0] wdata, input logic ecall, input logic mret, input logic ret,
    input logic irq, input logic [31:0] pcV, input logic chkRd, input logic [31:0] expRd,
    input logic expIll, input logic expTv, input logic [31:0] expTpc,
    input logic chkMepc, input logic [31:0] expMepc);
    exp_t e;
    rst = rstV; csrOp = op; csrAddr = addr; csrWdata = wdata;
    ecallEn = ecall; mretEn = mret; retire = ret; irqTimer = irq; pc = pcV;
    e = '{chkRd: chkRd, rd: expRd, ill: expIll, tv: expTv, tpc: expTpc,
          chkMepc: chkMepc, mepc: expMepc};
    expQ.push_back(e);
    nameQ.push_back(name);
    sampleEn = 1'b1;
    @(posedge clk);
    #1;
    sampleEn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csrOp = NONE; csrAddr = '0; csrWdata = '0;
    ecallEn = 1'b0; mretEn = 1'b0; retire = 1'b0; irqTimer = 1'b0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // name            rst op    addr     wdata         ec mr rt iq pc            chk rd            ill tv tpc           chkM mepc
    applyStimulus("rst_mstatus",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1800, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst_mtvec",    0, NONE, 12'h305, 32'h0,        0, 0, 0, 0, 32'h0,        1, MTVEC_RST,     0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst_mepc",     0, NONE, 12'h341, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        1, 32'h0);
    applyStimulus("rw_mtvec",     0, RW,   12'h305, 32'h8000_0103,0, 0, 0, 0, 32'h0,        1, MTVEC_RST,     0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rs0_mtvec",    0, RS,   12'h305, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h8000_0100, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rc0_mepc",     0, RC,   12'h341, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        1, 32'h0);
    applyStimulus("rd_mtvec",     0, NONE, 12'h305, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h8000_0100, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rw_mip",       0, RW,   12'h344, 32'h80,       0, 0, 0, 0, 32'h0,        1, 32'h0,         1, 0, 32'h0,        0, 32'h0);
    applyStimulus("rw_unmapped",  0, RW,   12'h7C0, 32'h5,        0, 0, 0, 0, 32'h0,        1, 32'h0,         1, 0, 32'h0,        0, 32'h0);
    applyStimulus("rw_c00",       0, RW,   12'hC00, 32'h1,        0, 0, 0, 0, 32'h0,        1, 32'h0,         1, 0, 32'h0,        0, 32'h0);
    applyStimulus("rs0_mip",      0, RS,   12'h344, 32'h0,        0, 0, 0, 1, 32'h0,        1, 32'h80,        0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rw_mie",       0, RW,   12'h304, 32'h80,       0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rs_mstatus",   0, RS,   12'h300, 32'h8,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1800, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rd_mstatus1",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1808, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rd_mie",       0, NONE, 12'h304, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h80,        0, 0, 32'h0,        0, 32'h0);
    applyStimulus("ecall",        0, NONE, 12'h300, 32'h0,        1, 0, 0, 0, 32'h8000_0040,1, 32'h0000_1808, 0, 1, 32'h8000_0100, 0, 32'h0);
    applyStimulus("ecall_mepc",   0, NONE, 12'h341, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h8000_0040, 0, 0, 32'h0,        1, 32'h8000_0040);
    applyStimulus("ecall_mcause", 0, NONE, 12'h342, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'd11,        0, 0, 32'h0,        0, 32'h0);
    applyStimulus("ecall_mstat",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mret1",        0, NONE, 12'h300, 32'h0,        0, 1, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 1, 32'h8000_0040, 0, 32'h0);
    applyStimulus("mret1_mstat",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1888, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("ecall_vs_irq", 0, RW,   12'h342, 32'h55,       1, 0, 1, 1, 32'h8000_0080,1, 32'd11,        0, 1, 32'h8000_0100, 0, 32'h0);
    applyStimulus("prio_mcause",  0, NONE, 12'h342, 32'h0,        0, 0, 1, 1, 32'h0,        1, 32'd11,        0, 0, 32'h0,        1, 32'h8000_0080);
    applyStimulus("prio_mstat",   0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mret2",        0, NONE, 12'h300, 32'h0,        0, 1, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 1, 32'h8000_0080, 1, 32'h8000_0080);
    applyStimulus("mret2_mstat",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1888, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("irq",          0, NONE, 12'h342, 32'h0,        0, 0, 1, 1, 32'h8000_00C4,1, 32'd11,        0, 1, 32'h8000_0100, 0, 32'h0);
    applyStimulus("irq_mcause",   0, NONE, 12'h342, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h8000_0007, 0, 0, 32'h0,        1, 32'h8000_00C4);
    applyStimulus("mret_swmepc",  0, RW,   12'h341, 32'h1234_5677,0, 1, 0, 0, 32'h0,        1, 32'h8000_00C4, 0, 1, 32'h8000_00C4, 0, 32'h0);
    applyStimulus("swmepc_rd",    0, NONE, 12'h341, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h1234_5674, 0, 0, 32'h0,        1, 32'h1234_5674);
    applyStimulus("wr_mcycle_lo", 0, RW,   12'hB00, 32'hFFFF_FFFF,0, 0, 0, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("wr_mcycle_hi", 0, RW,   12'hB80, 32'hFFFF_FFFF,0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mcycle_hi_rd", 0, NONE, 12'hB80, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFF, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mcycle_wrap",  0, NONE, 12'hB00, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mcycle_one",   0, NONE, 12'hB00, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h1,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("wr_minstret",  0, RW,   12'hB02, 32'h5,        0, 0, 1, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("minstret_5",   0, NONE, 12'hB02, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'h5,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("minstret_6",   0, NONE, 12'hB02, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h6,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("minstret_hold",0, NONE, 12'hB02, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h6,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rc_mie_bit",   0, RC,   12'h300, 32'h8,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1888, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rc_mstat_rd",  0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rc_mpp",       0, RC,   12'h300, 32'h1800,     0, 0, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("mpp_hardwire", 0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst_vs_ecall", 1, NONE, 12'h305, 32'h0,        1, 0, 0, 0, 32'h8000_0200,1, 32'h8000_0100, 0, 1, 32'h8000_0100, 1, 32'h1234_5674);
    applyStimulus("rst2_mcycle0", 0, NONE, 12'hB00, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst2_mcycle1", 0, NONE, 12'hB00, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h1,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst2_mtvec",   0, NONE, 12'h305, 32'h0,        0, 0, 0, 0, 32'h0,        1, MTVEC_RST,     0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst2_mcause",  0, NONE, 12'h342, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst2_mstatus", 0, NONE, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0000_1800, 0, 0, 32'h0,        0, 32'h0);
    applyStimulus("rst2_mepc",    0, NONE, 12'h341, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h0,         0, 0, 32'h0,        1, 32'h0);

    repeat (2) @(posedge clk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_csr_unit.md
YSYX_23060191_CSR_UNIT -- requirements
Module: ysyx_23060191_csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving datapath width (32 or 64).
REQ-002 SHALL have parameter MTVEC_RESET, default 0, giving the mtvec reset value.
REQ-003 SHALL have parameter HAS_COUNTERS, default 1; when 0, mcycle and minstret are absent and their addresses are illegal.
REQ-004 SHALL have one clock and a synchronous active-high reset: port clk, the single rising-edge clock, and port rst, the synchronous active-high reset.
REQ-005 SHALL have ports, one per entry:
- clk  in  1  clock
- rst  in  1  synchronous reset
- i_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  XLEN  source operand
- i_ecall_en  in  1  ecall this cycle
- i_mret_en  in  1  mret this cycle
- i_pc  in  XLEN  PC of the current instruction
- i_retire  in  1  instruction retires this cycle
- i_irq_timer  in  1  level timer interrupt
- o_csr_rdata  out  XLEN  old CSR value
- o_illegal  out  1  illegal CSR access
- o_trap_valid  out  1  redirect PC this cycle
- o_trap_pc  out  XLEN  redirect target
- o_mepc  out  XLEN  current mepc

Function
REQ-006 SHALL implement these CSRs:
- mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired to 11; all other bits read 0.
- mie 0x304: MTIE bit7 only.
- mtvec 0x305: bits[1:0] read 0 (direct mode).
- mepc 0x341: bits[1:0] read 0.
- mcause 0x342.
- mip 0x344: read-only; MTIP bit7 = i_irq_timer.
- mcycle 0xB00, minstret 0xB02; when XLEN=32, upper halves at 0xB80 and 0xB82.
REQ-007 SHALL drive o_csr_rdata combinationally with the pre-write value at i_csr_addr, and drive 0 when the address is unmapped.
REQ-008 SHALL compute the new value as: RW = wdata; RS = old | wdata; RC = old & ~wdata. The write commits on the next rising clk edge.
REQ-009 SHALL NOT write on RS or RC when i_csr_wdata == 0; the read still occurs.
REQ-010 SHALL assert o_illegal combinationally when op != 00 and either:
- the address is unmapped, or
- a write would occur to mip or to any address with addr[11:10] == 11.
On o_illegal no CSR changes.
REQ-011 SHALL take an ecall trap when i_ecall_en is high. On the edge: mepc <= i_pc, mcause <= 11, MPIE <= MIE, MIE <= 0.
REQ-012 SHALL take an interrupt when MIE & MTIE & i_irq_timer & i_retire are all high and i_ecall_en is low. On the edge: mepc <= i_pc, mcause <= {1, 0..0, 7}, MPIE <= MIE, MIE <= 0.
REQ-013 SHALL execute mret when i_mret_en is high and no trap is taken. On the edge: MIE <= MPIE, MPIE <= 1.
REQ-014 SHALL assert o_trap_valid combinationally for a trap or mret. o_trap_pc SHALL equal mtvec for a trap and mepc for mret; otherwise o_trap_pc = 0.
REQ-015 SHALL apply priority ecall > interrupt > mret. On the same edge, a trap/mret update to mstatus, mepc or mcause overrides a software write to that CSR; software writes to other CSRs still commit.
REQ-016 SHALL increment mcycle by 1 every cycle out of reset, and increment minstret by 1 on each cycle with i_retire high.
REQ-017 SHALL let a software write to any counter half take priority over that cycle's increment. Counters SHALL be 64-bit and wrap from all-ones to 0.
REQ-018 SHALL have o_mepc always equal the mepc register.

Reset
REQ-019 SHALL, on rst high at a clk edge, set:
- mstatus = 0x1800 (MIE = 0, MPIE = 0)
- mtvec = MTVEC_RESET
- mepc, mcause, mie = 0
- mcycle, minstret = 0
REQ-020 SHALL give rst priority over all traps, mret and writes in the same cycle. Combinational outputs during reset reflect current register contents.

Structure
REQ-021 SHALL place the following in package ysyx_23060191_csr_pkg:
- CSR address constants
- op encodings
- cause codes (ECALL_M = 11, MTI = 7)
- mstatus/mie/mip bit indices
REQ-022 SHALL instantiate sub-module ysyx_23060191_csr_counter twice (mcycle, minstret). It has: 64-bit count, increment enable, low/high/full write ports, synchronous reset.

Verification
REQ-023 Reset then read 0x300 -> o_csr_rdata = 0x1800; read 0x305 -> MTVEC_RESET.
REQ-024 RW 0x305 with 0x80000103; then RS 0x305 with 0; then RC 0x341 with 0 -> mtvec reads 0x80000100; the RS/RC with 0 cause no write and o_illegal = 0.
REQ-025 mtvec = 0x80000100, MIE = 1, i_pc = 0x80000040, pulse i_ecall_en -> o_trap_valid = 1, o_trap_pc = 0x80000100; next cycle mepc = 0x80000040, mcause = 11, mstatus = 0x1880.
REQ-026 MIE = 1, MTIE = 1, i_irq_timer = 1, i_retire = 1, i_ecall_en = 1 in the same cycle -> mcause = 11 (ecall wins); after mret -> MIE = 1, o_trap_pc = mepc.
REQ-027 RW 0x344, or RW on unmapped 0x7C0 -> o_illegal = 1 with no state change; XLEN=32, write 0xB00 = 0xFFFFFFFF and 0xB80 = 0xFFFFFFFF -> after 2 cycles mcycle = 1.
